// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - measurement result bundle published by pwm_capture
interface pwm_capture_if #(
    parameter int CNT_W = 16
);
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] top_est;
    logic             valid;
    logic             timeout;

    modport master (
        output period,
        output high_time,
        output top_est,
        output valid,
        output timeout
    );

    modport slave (
        input  period,
        input  high_time,
        input  top_est,
        input  valid,
        input  timeout
    );
endinterface

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time capture; optional glitch filter via PWM_CAPTURE_GLITCH_FILTER_EN
module pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          GPIO_in,
    input  logic          enable,
    pwm_capture_if.master cap
);
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic               w_synced;
    logic               w_level;
    logic               r_prev;
    logic               w_rise;
    logic               w_fall;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_cnt_max;
    logic [CNT_W-1:0]   r_hi_cap;
    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   r_high_time;
    logic [CNT_W-1:0]   r_top_est;
    logic               r_valid;
    logic               r_timeout;
    logic               w_cnt_clr;
    logic               w_hi_load;
    logic               w_publish;
    logic               w_missed_fall;
    logic               w_to_set;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], GPIO_in};
        end
    end

    assign w_synced = r_sync[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int FC_W = $clog2(FILTER_LEN + 1);

    logic            r_filt;
    logic [FC_W-1:0] r_fcnt;

    // Level flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filt <= 1'b0;
            r_fcnt <= '0;
        end else if (w_synced == r_filt) begin
            r_fcnt <= '0;
        end else if (r_fcnt == FC_W'(FILTER_LEN - 1)) begin
            r_filt <= w_synced;
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + FC_W'(1);
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = w_synced;
`endif

    assign w_rise    = w_level & ~r_prev;
    assign w_fall    = ~w_level & r_prev;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_cnt_max = &r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_cnt_clr     = 1'b0;
        w_hi_load     = 1'b0;
        w_publish     = 1'b0;
        w_missed_fall = 1'b0;
        w_to_set      = 1'b0;
        if (!enable) begin
            w_next    = S_IDLE;
            w_cnt_clr = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_next    = S_ARM;
                    w_cnt_clr = 1'b1;
                end
                S_ARM: begin
                    if (w_rise) begin
                        w_next = S_HIGH;
                    end else if (w_cnt_max) begin
                        w_to_set = 1'b1;
                    end
                end
                S_HIGH: begin
                    // Saturation wins over a coincident edge so cnt+1 never wraps.
                    if (w_cnt_max) begin
                        w_to_set = 1'b1;
                        w_next   = S_ARM;
                    end else if (w_rise) begin
                        w_publish     = 1'b1;
                        w_missed_fall = 1'b1;
                    end else if (w_fall) begin
                        w_hi_load = 1'b1;
                        w_next    = S_LOW;
                    end
                end
                S_LOW: begin
                    if (w_cnt_max) begin
                        w_to_set = 1'b1;
                        w_next   = S_ARM;
                    end else if (w_rise) begin
                        w_publish = 1'b1;
                        w_next    = S_HIGH;
                    end
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev      <= 1'b0;
            r_cnt       <= '0;
            r_hi_cap    <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_top_est   <= '0;
            r_valid     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_prev  <= w_level;
            r_valid <= w_publish;
            if (w_cnt_clr || w_rise) begin
                r_cnt <= '0;
            end else if (!w_cnt_max) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_hi_load) begin
                r_hi_cap <= w_cnt_inc;
            end
            if (w_publish) begin
                r_period    <= w_cnt_inc;
                r_high_time <= w_missed_fall ? w_cnt_inc : r_hi_cap;
                r_top_est   <= r_cnt;
                r_timeout   <= 1'b0;
            end else if (w_to_set) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign cap.period    = r_period;
    assign cap.high_time = r_high_time;
    assign cap.top_est   = r_top_est;
    assign cap.valid     = r_valid;
    assign cap.timeout   = r_timeout;
endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;
    localparam int CNT_W = 16;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int HI = 4;
`else
    localparam int HI = 3;
`endif
    localparam int LO = 10 - HI;

    logic clk = 1'b0;
    logic reset_n;
    logic GPIO_in;
    logic enable;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   c0;

    logic [CNT_W-1:0] q_per[$];
    logic [CNT_W-1:0] q_hi[$];
    logic [CNT_W-1:0] q_top[$];
    logic             q_to[$];
    int               q_cyc[$];

    pwm_capture_if #(.CNT_W(CNT_W)) cap_if ();

    pwm_capture #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2),
        .FILTER_LEN (4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .GPIO_in(GPIO_in),
        .enable (enable),
        .cap    (cap_if.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (cap_if.valid === 1'b1) begin
            q_per.push_back(cap_if.period);
            q_hi.push_back(cap_if.high_time);
            q_top.push_back(cap_if.top_est);
            q_to.push_back(cap_if.timeout);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_wave(input int hi, input int lo, input int n);
        repeat (n) begin
            GPIO_in = 1'b1;
            repeat (hi) @(negedge clk);
            GPIO_in = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic settle();
        GPIO_in = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        GPIO_in = 1'b0;
        #1;
        check_eq("rst_period", cap_if.period, 0);
        check_eq("rst_high", cap_if.high_time, 0);
        check_eq("rst_top", cap_if.top_est, 0);
        check_eq("rst_valid", cap_if.valid, 0);
        check_eq("rst_timeout", cap_if.timeout, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (2) @(negedge clk);

        // Basic wave: 5 rises, the first only arms the measurement.
        drive_wave(HI, LO, 5);
        settle();
        check_eq("w1_count", q_per.size(), 4);
        check_eq("w1_period", q_per[$], 10);
        check_eq("w1_high", q_hi[$], HI);
        check_eq("w1_top", q_top[$], 9);
        check_eq("w1_timeout", cap_if.timeout, 0);
        check_eq("w1_gap", q_cyc[$] - q_cyc[$-1], 10);

        // Generator round trip, Top=9 -> 50% duty.
        drive_wave(5, 5, 4);
        settle();
        check_eq("rt_period", q_per[$], 10);
        check_eq("rt_high", q_hi[$], 5);
        check_eq("rt_top", q_top[$], 9);

`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
        drive_wave(1, 1, 8);
        settle();
        check_eq("tog_period", q_per[$], 2);
        check_eq("tog_high", q_hi[$], 1);
        check_eq("tog_top", q_top[$], 1);
        check_eq("tog_gap", q_cyc[$] - q_cyc[$-1], 2);
`endif

        // Disabled: no strobes, outputs frozen.
        c0 = q_per.size();
        enable = 1'b0;
        drive_wave(HI, LO, 3);
        settle();
        check_eq("dis_count", q_per.size(), c0);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        check_eq("dis_period", cap_if.period, 10);
        check_eq("dis_high", cap_if.high_time, 5);
        check_eq("dis_top", cap_if.top_est, 9);
`else
        check_eq("dis_period", cap_if.period, 2);
        check_eq("dis_high", cap_if.high_time, 1);
        check_eq("dis_top", cap_if.top_est, 1);
`endif
        enable = 1'b1;
        @(negedge clk);
        drive_wave(HI, LO, 3);
        settle();
        check_eq("reen_count", q_per.size(), c0 + 2);
        check_eq("reen_period", q_per[$], 10);

        // Asynchronous reset in the middle of a low phase.
        GPIO_in = 1'b1;
        repeat (HI) @(negedge clk);
        GPIO_in = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_period", cap_if.period, 0);
        check_eq("arst_high", cap_if.high_time, 0);
        check_eq("arst_top", cap_if.top_est, 0);
        check_eq("arst_valid", cap_if.valid, 0);
        check_eq("arst_timeout", cap_if.timeout, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        c0 = q_per.size();
        @(negedge clk);
        drive_wave(HI, LO, 3);
        settle();
        check_eq("post_rst_count", q_per.size(), c0 + 2);
        check_eq("post_rst_period", q_per[$], 10);

        // Constant low input must end in timeout.
        c0 = q_per.size();
        repeat (65540) @(negedge clk);
        check_eq("to_level", cap_if.timeout, 1);
        check_eq("to_no_valid", q_per.size(), c0);
        drive_wave(HI, LO, 1);
        check_eq("to_after_arm", cap_if.timeout, 1);
        check_eq("to_arm_no_valid", q_per.size(), c0);
        drive_wave(HI, LO, 2);
        settle();
        check_eq("to_resume_count", q_per.size(), c0 + 2);
        check_eq("to_first_period", q_per[c0], 10);
        check_eq("to_cleared_at_valid", q_to[c0], 0);
        check_eq("to_cleared", cap_if.timeout, 0);

        // One-cycle spike inside the low phase.
        drive_wave(HI, LO, 1);
        c0 = q_per.size();
        GPIO_in = 1'b1;
        repeat (HI) @(negedge clk);
        GPIO_in = 1'b0;
        repeat (4) @(negedge clk);
        GPIO_in = 1'b1;
        @(negedge clk);
        GPIO_in = 1'b0;
        repeat (10 - HI - 5) @(negedge clk);
        drive_wave(HI, LO, 1);
        settle();
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        check_eq("spk_count", q_per.size(), c0 + 2);
        check_eq("spk_period", q_per[c0+1], 10);
        check_eq("spk_high", q_hi[c0+1], HI);
`else
        check_eq("spk_count", q_per.size(), c0 + 3);
        check_eq("spk_short_period", q_per[c0+1], 7);
        check_eq("spk_short_high", q_hi[c0+1], 3);
        check_eq("spk_tail_period", q_per[c0+2], 3);
        check_eq("spk_tail_high", q_hi[c0+2], 1);
        check_eq("spk_tail_top", q_top[c0+2], 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
